// File: rtl/ldw_id_pipe.sv
// ldw_id_pipe -- decode (ID) stage of the 5-stage pipelined CPU.
//
// Holds the NREG x XLEN register file, selects forwarded operands, resolves
// branches and jumps in ID, detects load-use / no-forward hazards and owns
// the ID/EX pipeline register (bubble on stall or empty IF/ID).
//
// Ports
//   clk, clr                    clock, asynchronous active-high reset
//   inst_valid, inst, dpc4      IF/ID contents (instruction, PC+4)
//   d_*                         decoded controls from the external control unit
//   ern/ewreg/em2reg/ealu       EX-stage destination info and ALU result
//   mrn/mwreg/mm2reg/malu/mmo   MEM-stage destination info, ALU result, load data
//   wrn/wwreg/wdi               writeback port
//   nostall, flush_if           PC/IFID hold, IF/ID cancel (BDS=0 only)
//   pcsource, bpc, jpc, rpc     next-PC select and candidate targets
//   e_*                         registered ID/EX outputs
module ldw_id_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int BDS  = 1,
  parameter int FWD  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] dpc4,
  input  logic            d_wreg,
  input  logic            d_m2reg,
  input  logic            d_wmem,
  input  logic            d_aluimm,
  input  logic            d_shift,
  input  logic            d_jal,
  input  logic            d_regrt,
  input  logic            d_sext,
  input  logic [3:0]      d_aluc,
  input  logic            d_use_rs,
  input  logic            d_use_rt,
  input  logic [1:0]      d_br,
  input  logic            d_jmp,
  input  logic [AW-1:0]   ern,
  input  logic            ewreg,
  input  logic            em2reg,
  input  logic [AW-1:0]   mrn,
  input  logic            mwreg,
  input  logic            mm2reg,
  input  logic [XLEN-1:0] ealu,
  input  logic [XLEN-1:0] malu,
  input  logic [XLEN-1:0] mmo,
  input  logic [AW-1:0]   wrn,
  input  logic            wwreg,
  input  logic [XLEN-1:0] wdi,
  output logic            nostall,
  output logic            flush_if,
  output logic [1:0]      pcsource,
  output logic [XLEN-1:0] bpc,
  output logic [XLEN-1:0] jpc,
  output logic [XLEN-1:0] rpc,
  output logic            e_valid,
  output logic            e_wreg,
  output logic            e_m2reg,
  output logic            e_wmem,
  output logic            e_aluimm,
  output logic            e_shift,
  output logic            e_jal,
  output logic [3:0]      e_aluc,
  output logic [XLEN-1:0] e_a,
  output logic [XLEN-1:0] e_b,
  output logic [XLEN-1:0] e_imm,
  output logic [XLEN-1:0] e_pc4,
  output logic [AW-1:0]   e_rn
);

  logic [XLEN-1:0] rf [NREG];

  logic [AW-1:0]          rs, rt, rd;
  logic                   use_rs, use_rt, stall, load;
  logic [XLEN-1:0]        opa, opb, imm;
  logic signed [XLEN-1:0] boff;
  logic                   unused_inst;

  assign rs = inst[21 +: AW];
  assign rt = inst[16 +: AW];
  assign rd = inst[11 +: AW];
  // Opcode/funct bits are decoded outside this block.
  assign unused_inst = ^inst;

  // Write-through read: a same-cycle writeback is visible to ID.
  function automatic logic [XLEN-1:0] rf_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (wwreg && wrn == a) return wdi;
    return rf[a];
  endfunction

  // EX beats MEM; an EX load has no data yet and is covered by the stall.
  function automatic logic [XLEN-1:0] sel_operand(input logic [AW-1:0] a);
    if (FWD != 0 && a != '0) begin
      if (ewreg && !em2reg && ern == a) return ealu;
      if (mwreg && mrn == a) return mm2reg ? mmo : malu;
    end
    return rf_read(a);
  endfunction

  function automatic logic hazard(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    if (FWD != 0) return ewreg && em2reg && ern == a;
    return (ewreg && ern == a) || (mwreg && mrn == a);
  endfunction

  always_comb begin
    // Branches compare both registers regardless of the use flags.
    use_rs = d_use_rs | (d_br != 2'b00);
    use_rt = d_use_rt | (d_br != 2'b00);
    stall  = inst_valid & ((use_rs & hazard(rs)) | (use_rt & hazard(rt)));
    load   = inst_valid & ~stall;
    opa    = sel_operand(rs);
    opb    = sel_operand(rt);
    imm    = {{(XLEN-16){d_sext & inst[15]}}, inst[15:0]};
    boff   = $signed(imm) <<< 2;

    pcsource = 2'b00;
    if (load) begin
      if (d_br == 2'b01 && opa == opb)      pcsource = 2'b01;
      else if (d_br == 2'b10 && opa != opb) pcsource = 2'b01;
      else if (d_br == 2'b11)               pcsource = 2'b10;
      else if (d_jmp)                       pcsource = 2'b11;
    end
  end

  assign nostall  = ~stall;
  assign flush_if = (BDS == 0) && (pcsource != 2'b00);
  assign bpc      = dpc4 + $unsigned(boff);
  assign jpc      = {dpc4[XLEN-1:28], inst[25:0], 2'b00};
  assign rpc      = opa;

  // Register file
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wwreg && wrn != '0) begin
      rf[wrn] <= wdi;
    end
  end

  // ID -> EX boundary: bubble clears only the state-changing controls
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      e_valid  <= 1'b0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_shift  <= 1'b0;
      e_jal    <= 1'b0;
      e_aluc   <= '0;
      e_a      <= '0;
      e_b      <= '0;
      e_imm    <= '0;
      e_pc4    <= '0;
      e_rn     <= '0;
    end else begin
      e_valid  <= load;
      e_wreg   <= load & d_wreg;
      e_wmem   <= load & d_wmem;
      e_m2reg  <= d_m2reg;
      e_aluimm <= d_aluimm;
      e_shift  <= d_shift;
      e_jal    <= d_jal;
      e_aluc   <= d_aluc;
      e_a      <= opa;
      e_b      <= opb;
      e_imm    <= imm;
      e_pc4    <= dpc4;
      e_rn     <= d_jal ? AW'(NREG-1) : (d_regrt ? rt : rd);
    end
  end

endmodule

// File: tb/tb_ldw_id_pipe.sv
module tb_ldw_id_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, inst_valid;
  logic [31:0] inst, dpc4;
  logic        d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal, d_regrt, d_sext;
  logic [3:0]  d_aluc;
  logic        d_use_rs, d_use_rt, d_jmp;
  logic [1:0]  d_br;
  logic [4:0]  ern, mrn, wrn;
  logic        ewreg, em2reg, mwreg, mm2reg, wwreg;
  logic [31:0] ealu, malu, mmo, wdi;

  // Three instances: 0 = BDS1/FWD1, 1 = BDS0/FWD1, 2 = BDS1/FWD0
  logic        o_ns [3], o_fl [3], o_ev [3], o_ew [3], o_em [3], o_ewm [3];
  logic        o_eai [3], o_esh [3], o_ej [3];
  logic [1:0]  o_pcs [3];
  logic [3:0]  o_aluc [3];
  logic [31:0] o_bpc [3], o_jpc [3], o_rpc [3], o_ea [3], o_eb [3], o_eimm [3], o_epc4 [3];
  logic [4:0]  o_rn [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ldw_id_pipe #(.XLEN(32), .NREG(32), .BDS(g == 1 ? 0 : 1), .FWD(g == 2 ? 0 : 1)) u_dut (
      .clk(clk), .clr(clr), .inst_valid(inst_valid), .inst(inst), .dpc4(dpc4),
      .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_aluimm(d_aluimm),
      .d_shift(d_shift), .d_jal(d_jal), .d_regrt(d_regrt), .d_sext(d_sext),
      .d_aluc(d_aluc), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_br(d_br), .d_jmp(d_jmp),
      .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
      .ealu(ealu), .malu(malu), .mmo(mmo), .wrn(wrn), .wwreg(wwreg), .wdi(wdi),
      .nostall(o_ns[g]), .flush_if(o_fl[g]), .pcsource(o_pcs[g]),
      .bpc(o_bpc[g]), .jpc(o_jpc[g]), .rpc(o_rpc[g]),
      .e_valid(o_ev[g]), .e_wreg(o_ew[g]), .e_m2reg(o_em[g]), .e_wmem(o_ewm[g]),
      .e_aluimm(o_eai[g]), .e_shift(o_esh[g]), .e_jal(o_ej[g]), .e_aluc(o_aluc[g]),
      .e_a(o_ea[g]), .e_b(o_eb[g]), .e_imm(o_eimm[g]), .e_pc4(o_epc4[g]), .e_rn(o_rn[g])
    );
  end

  typedef struct {
    logic        v, w, m2, wm, ai, sh, j;
    logic [3:0]  aluc;
    logic [31:0] a, b, imm, pc4;
    logic [4:0]  rn;
  } exp_t;

  exp_t        ex [3];
  logic [31:0] mrf [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic int fwd_of(input int k); return (k == 2) ? 0 : 1; endfunction
  function automatic int bds_of(input int k); return (k == 1) ? 0 : 1; endfunction

  function automatic logic [31:0] r_type(input logic [4:0] s, t, d);
    return {6'd0, s, t, d, 11'd0};
  endfunction
  function automatic logic [31:0] i_type(input logic [4:0] s, t, input logic [15:0] im);
    return {6'h23, s, t, im};
  endfunction

  // Value a source register holds as seen by ID, from the in-flight writers.
  function automatic logic [31:0] operand(input int fwd, input logic [4:0] src);
    if (src == 0) return 32'd0;
    if (fwd != 0 && ewreg && !em2reg && ern == src) return ealu;
    if (fwd != 0 && mwreg && mrn == src) return mm2reg ? mmo : malu;
    if (wwreg && wrn == src) return wdi;
    return mrf[src];
  endfunction

  function automatic logic pending(input int fwd, input logic [4:0] src);
    if (src == 0) return 1'b0;
    if (fwd != 0) return ewreg && em2reg && ern == src;
    return (ewreg && ern == src) || (mwreg && mrn == src);
  endfunction

  task automatic ref_id(input int fwd, input int bds, output logic st, output logic [1:0] pcs,
                        output logic fl, output logic [31:0] a, output logic [31:0] b);
    logic [4:0] s, t;
    logic       reads_s, reads_t;
    s = inst[25:21];
    t = inst[20:16];
    reads_s = d_use_rs || d_br != 2'b00;
    reads_t = d_use_rt || d_br != 2'b00;
    st = inst_valid && ((reads_s && pending(fwd, s)) || (reads_t && pending(fwd, t)));
    a = operand(fwd, s);
    b = operand(fwd, t);
    pcs = 2'b00;
    if (inst_valid && !st) begin
      case (d_br)
        2'b01: if (a == b) pcs = 2'b01;
        2'b10: if (a != b) pcs = 2'b01;
        2'b11: pcs = 2'b10;
        default: if (d_jmp) pcs = 2'b11;
      endcase
    end
    fl = (bds == 0) && (pcs != 2'b00);
  endtask

  task automatic idle();
    inst_valid = 0; inst = 0; dpc4 = 0;
    d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_aluimm = 0; d_shift = 0; d_jal = 0;
    d_regrt = 0; d_sext = 0; d_aluc = 0; d_use_rs = 0; d_use_rt = 0; d_br = 0; d_jmp = 0;
    ern = 0; ewreg = 0; em2reg = 0; mrn = 0; mwreg = 0; mm2reg = 0;
    ealu = 0; malu = 0; mmo = 0; wrn = 0; wwreg = 0; wdi = 0;
  endtask

  task automatic chk_e(input string tag);
    for (int k = 0; k < 3; k++) begin
      string t;
      t = $sformatf("%s[%0d]", tag, k);
      chk({t, "/e_valid"}, o_ev[k], ex[k].v);
      chk({t, "/e_wreg"}, o_ew[k], ex[k].w);
      chk({t, "/e_wmem"}, o_ewm[k], ex[k].wm);
      if (ex[k].v) begin
        chk({t, "/e_m2reg"}, o_em[k], ex[k].m2);
        chk({t, "/e_aluimm"}, o_eai[k], ex[k].ai);
        chk({t, "/e_shift"}, o_esh[k], ex[k].sh);
        chk({t, "/e_jal"}, o_ej[k], ex[k].j);
        chk({t, "/e_aluc"}, o_aluc[k], ex[k].aluc);
        chk({t, "/e_a"}, o_ea[k], ex[k].a);
        chk({t, "/e_b"}, o_eb[k], ex[k].b);
        chk({t, "/e_imm"}, o_eimm[k], ex[k].imm);
        chk({t, "/e_pc4"}, o_epc4[k], ex[k].pc4);
        chk({t, "/e_rn"}, o_rn[k], ex[k].rn);
      end
    end
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step(input string tag);
    logic        st, fl;
    logic [1:0]  pcs;
    logic [31:0] a, b, imm;
    #3;
    imm = {{16{d_sext & inst[15]}}, inst[15:0]};
    for (int k = 0; k < 3; k++) begin
      string t;
      t = $sformatf("%s[%0d]", tag, k);
      ref_id(fwd_of(k), bds_of(k), st, pcs, fl, a, b);
      chk({t, "/nostall"}, o_ns[k], !st);
      chk({t, "/pcsource"}, o_pcs[k], pcs);
      chk({t, "/flush_if"}, o_fl[k], fl);
      chk({t, "/bpc"}, o_bpc[k], dpc4 + (imm << 2));
      chk({t, "/jpc"}, o_jpc[k], {dpc4[31:28], inst[25:0], 2'b00});
      chk({t, "/rpc"}, o_rpc[k], a);
      ex[k].v    = inst_valid && !st;
      ex[k].w    = ex[k].v && d_wreg;
      ex[k].wm   = ex[k].v && d_wmem;
      ex[k].m2   = d_m2reg;
      ex[k].ai   = d_aluimm;
      ex[k].sh   = d_shift;
      ex[k].j    = d_jal;
      ex[k].aluc = d_aluc;
      ex[k].a    = a;
      ex[k].b    = b;
      ex[k].imm  = imm;
      ex[k].pc4  = dpc4;
      ex[k].rn   = d_jal ? 5'd31 : (d_regrt ? inst[20:16] : inst[15:11]);
    end
    @(posedge clk);
    #1;
    if (wwreg && wrn != 0) mrf[wrn] = wdi;
    chk_e(tag);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    clr = 1'b1;
    idle();
    #7;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_e_valid[%0d]", k), o_ev[k], 1'b0);
      chk($sformatf("rst_e_a[%0d]", k), o_ea[k], 32'd0);
    end
    @(posedge clk);
    #1 clr = 1'b0;

    // Write-through: WB writes r5 while ID reads it
    idle(); inst_valid = 1; inst = r_type(5'd5, 5'd0, 5'd9); d_use_rs = 1; d_use_rt = 1;
    d_wreg = 1; dpc4 = 32'h40; wwreg = 1; wrn = 5; wdi = 32'hDEAD;
    step("t5_wt");
    chk("t5_wt_e_a", o_ea[0], 32'hDEAD);
    idle(); wwreg = 1; wrn = 0; wdi = 32'h1234;
    step("t5_w0");
    idle(); inst_valid = 1; inst = r_type(5'd0, 5'd5, 5'd8); d_use_rs = 1; d_use_rt = 1; d_wreg = 1;
    step("t5_r0");
    chk("t5_r0_e_a", o_ea[0], 32'd0);
    chk("t5_r0_e_b", o_eb[0], 32'hDEAD);

    // EX beats MEM for the same destination
    idle(); inst_valid = 1; inst = r_type(5'd3, 5'd0, 5'd4); d_use_rs = 1; d_use_rt = 1; d_wreg = 1;
    ewreg = 1; ern = 3; ealu = 32'h11; mwreg = 1; mrn = 3; malu = 32'h22;
    step("t2_prio");
    chk("t2_e_a", o_ea[0], 32'h11);
    chk("t2_e_rn", o_rn[0], 32'd4);

    // Load-use: one bubble, then forward load data from MEM
    idle(); inst_valid = 1; inst = r_type(5'd2, 5'd0, 5'd4); d_use_rs = 1; d_use_rt = 1; d_wreg = 1;
    ewreg = 1; em2reg = 1; ern = 2; ealu = 32'h55;
    #1 chk("t3_nostall", o_ns[0], 1'b0);
    step("t3_lu");
    chk("t3_bubble", o_ev[0], 1'b0);
    ewreg = 0; em2reg = 0; ern = 0; mwreg = 1; mrn = 2; mm2reg = 1; mmo = 32'hCAFE; malu = 32'h99;
    #1 chk("t3_release", o_ns[0], 1'b1);
    step("t3_fwd");
    chk("t3_e_a", o_ea[0], 32'hCAFE);
    chk("t3_e_valid", o_ev[0], 1'b1);

    // Taken beq, with and without delay slot
    idle(); inst_valid = 1; inst = i_type(5'd1, 5'd1, 16'h0004); d_br = 2'b01; d_sext = 1;
    dpc4 = 32'h100;
    #1;
    chk("t4_pcsource", o_pcs[0], 2'b01);
    chk("t4_bpc", o_bpc[0], 32'h110);
    chk("t4_flush_bds0", o_fl[1], 1'b1);
    chk("t4_flush_bds1", o_fl[0], 1'b0);
    step("t4_beq");

    // No forwarding: addi r6 then add r7,r6,r6 stalls twice
    idle(); inst_valid = 1; inst = i_type(5'd0, 5'd6, 16'h0077); d_use_rs = 1;
    d_wreg = 1; d_regrt = 1; d_aluimm = 1; d_sext = 1;
    step("t6_addi");
    idle(); inst_valid = 1; inst = r_type(5'd6, 5'd6, 5'd7); d_use_rs = 1; d_use_rt = 1; d_wreg = 1;
    ewreg = 1; ern = 6; ealu = 32'h77;
    #1 chk("t6_stall1", o_ns[2], 1'b0);
    step("t6_s1");
    ewreg = 0; ern = 0; mwreg = 1; mrn = 6; malu = 32'h77;
    #1 chk("t6_stall2", o_ns[2], 1'b0);
    step("t6_s2");
    mwreg = 0; mrn = 0; wwreg = 1; wrn = 6; wdi = 32'h77;
    #1 chk("t6_go", o_ns[2], 1'b1);
    step("t6_go");
    chk("t6_e_a", o_ea[2], 32'h77);
    chk("t6_e_b", o_eb[2], 32'h77);

    // Asynchronous clear while ID/EX holds a valid lw
    idle(); inst_valid = 1; inst = i_type(5'd5, 5'd8, 16'h0000); d_use_rs = 1;
    d_wreg = 1; d_m2reg = 1; d_aluimm = 1; d_regrt = 1; d_sext = 1; dpc4 = 32'h200;
    step("t1_lw");
    chk("t1_lw_valid", o_ev[0], 1'b1);
    idle();
    #2 clr = 1'b1;
    #1;
    chk("t1_e_valid", o_ev[0], 1'b0);
    chk("t1_e_wreg", o_ew[0], 1'b0);
    chk("t1_e_m2reg", o_em[0], 1'b0);
    chk("t1_e_a", o_ea[0], 32'd0);
    chk("t1_e_pc4", o_epc4[0], 32'd0);
    chk("t1_e_rn", o_rn[0], 32'd0);
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    #2 clr = 1'b0;
    #1 chk("t1_nostall", o_ns[0], 1'b1);
    @(posedge clk);
    #1;
    idle(); inst_valid = 1; inst = r_type(5'd5, 5'd0, 5'd9); d_use_rs = 1; d_use_rt = 1; d_wreg = 1;
    step("t1_rd");
    chk("t1_rf_cleared", o_ea[0], 32'd0);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 250; n++) begin
      inst_valid = ($urandom_range(0, 9) != 0);
      inst = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 11'($urandom)};
      dpc4 = $urandom;
      {d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal, d_regrt, d_sext} = 8'($urandom);
      d_aluc = 4'($urandom);
      d_use_rs = 1'($urandom); d_use_rt = 1'($urandom);
      d_br = 2'($urandom);
      d_jmp = (d_br == 2'b00) ? 1'($urandom) : 1'b0;
      ern = 5'($urandom_range(0, 7)); ewreg = 1'($urandom); em2reg = 1'($urandom);
      mrn = 5'($urandom_range(0, 7)); mwreg = 1'($urandom); mm2reg = 1'($urandom);
      ealu = $urandom; malu = $urandom; mmo = $urandom;
      wrn = 5'($urandom_range(0, 7)); wwreg = 1'($urandom); wdi = $urandom;
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
